// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: writeback sources, access sizes, FSM states.
// Bit numbering in the interface is descending: addr[1:0] is the byte offset within a word.
package mem_stage_pkg;

  localparam logic [1:0] DIN_ALU = 2'd0;
  localparam logic [1:0] DIN_FPU = 2'd1;
  localparam logic [1:0] DIN_MEM = 2'd2;
  localparam logic [1:0] DIN_PC  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic logic is_mem_op(input logic [1:0] src, input logic we);
    return (src == DIN_MEM) | we;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: replicates store data into lanes with byte enables,
// and extracts/extends load data. Lane 0 is the most significant byte.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        ext,
  input  logic [31:0] reg_b,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata   = 32'h0;
    byte_en = 4'b0000;
    case (size)
      SZ_BYTE: begin
        wdata   = {4{reg_b[7:0]}};
        byte_en = 4'b1000 >> lane;
      end
      SZ_HALF: begin
        wdata   = {2{reg_b[15:0]}};
        byte_en = lane[1] ? 4'b0011 : 4'b1100;
      end
      SZ_WORD: begin
        wdata   = reg_b;
        byte_en = 4'b1111;
      end
      default: ;
    endcase
  end

  // Lane 0 sits in the top byte, so the shift amount is the inverted lane index.
  always_comb begin
    ld_byte   = rdata[{~lane, 3'b000} +: 8];
    ld_half   = lane[1] ? rdata[15:0] : rdata[31:16];
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{ext & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = {{16{ext & ld_half[15]}}, ld_half};
      SZ_WORD: load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute bundle, runs one req/ack data-memory access,
// and freezes upstream via StallOut until the ack; a late freeze parks load data in hold_buf.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       NextALUOut,
  input  logic [31:0]       NextFPUOut,
  input  logic [DATA_W-1:0] NextRegB,
  input  logic [31:0]       NextPCPlusFour,
  input  logic [1:0]        NextDInSrc,
  input  logic              NextRegWE,
  input  logic [5:0]        NextRegWAddr,
  input  logic [1:0]        NextMEMSize,
  input  logic              NextMEMWE,
  input  logic              NextExtMEM,
  output logic [ADDR_W-1:0] DMemAddr,
  output logic [DATA_W-1:0] DMemWData,
  output logic [3:0]        DMemByteEn,
  output logic              DMemReq,
  output logic              DMemWE,
  input  logic [DATA_W-1:0] DMemRData,
  input  logic              DMemAck,
  output logic              StallOut,
  output logic              MisalignFault,
  output logic [31:0]       MemData,
  output logic [DATA_W-1:0] LoadData,
  output logic [31:0]       ALUOut,
  output logic [31:0]       FPUOut,
  output logic [31:0]       PCPlusFour,
  output logic [1:0]        DInSrc,
  output logic              RegWE,
  output logic [5:0]        RegWAddr
);

  logic [31:0]       alu_out, fpu_out, pc4;
  logic [DATA_W-1:0] reg_b, hold_buf;
  logic [1:0]        din_src, mem_size, state, state_nxt;
  logic              reg_we, mem_we, ext_mem;
  logic [5:0]        reg_waddr;

  logic              cap_en, in_access, mem_op, fault, access_ok, park;
  logic [DATA_W-1:0] wdata, load_ext;
  logic [3:0]        byte_en;

  assign in_access = (state == ST_ACCESS);
  assign StallOut  = in_access & ~DMemAck;
  assign cap_en    = ~stall & ~StallOut;
  assign park      = in_access & DMemAck & stall;

  always_comb begin
    state_nxt = state;
    if (cap_en)
      state_nxt = (is_mem_op(NextDInSrc, NextMEMWE) &
                   ~is_misaligned(NextMEMSize, NextALUOut[1:0])) ? ST_ACCESS : ST_IDLE;
    else if (park)
      state_nxt = ST_HOLD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out   <= '0;
      fpu_out   <= '0;
      reg_b     <= '0;
      pc4       <= '0;
      din_src   <= '0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      mem_size  <= '0;
      mem_we    <= 1'b0;
      ext_mem   <= 1'b0;
      state     <= ST_IDLE;
      hold_buf  <= '0;
    end else begin
      state <= state_nxt;
      if (park)
        hold_buf <= load_ext;
      if (cap_en) begin
        alu_out   <= NextALUOut;
        fpu_out   <= NextFPUOut;
        reg_b     <= NextRegB;
        pc4       <= NextPCPlusFour;
        din_src   <= NextDInSrc;
        reg_we    <= NextRegWE;
        reg_waddr <= NextRegWAddr;
        mem_size  <= NextMEMSize;
        mem_we    <= NextMEMWE;
        ext_mem   <= NextExtMEM;
      end
    end
  end

  mem_lane_align u_align (
    .size      (mem_size),
    .lane      (alu_out[1:0]),
    .ext       (ext_mem),
    .reg_b     (reg_b),
    .rdata     (DMemRData),
    .wdata     (wdata),
    .byte_en   (byte_en),
    .load_data (load_ext)
  );

  assign mem_op        = is_mem_op(din_src, mem_we);
  assign fault         = is_misaligned(mem_size, alu_out[1:0]);
  assign access_ok     = mem_op & ~fault;
  assign MisalignFault = mem_op & fault;

  // Faulting ops never reach ACCESS, so the request needs no separate fault gate.
  assign DMemReq    = in_access;
  assign DMemAddr   = {alu_out[ADDR_W-1:2], 2'b00};
  assign DMemByteEn = access_ok ? byte_en : 4'b0000;
  assign DMemWE     = mem_we & ~fault;
  assign DMemWData  = DMemWE ? wdata : '0;

  always_comb begin
    case (state)
      ST_ACCESS: LoadData = load_ext;
      ST_HOLD:   LoadData = hold_buf;
      default:   LoadData = '0;
    endcase
  end

  always_comb begin
    case (din_src)
      DIN_FPU: MemData = fpu_out;
      DIN_PC:  MemData = pc4;
      default: MemData = alu_out;
    endcase
  end

  assign ALUOut     = alu_out;
  assign FPUOut     = fpu_out;
  assign PCPlusFour = pc4;
  assign DInSrc     = din_src;
  assign RegWAddr   = reg_waddr;
  assign RegWE      = reg_we & ~StallOut & ~MisalignFault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs are checked 1ns later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] NextALUOut, NextFPUOut, NextRegB, NextPCPlusFour;
  logic [1:0]  NextDInSrc, NextMEMSize;
  logic        NextRegWE, NextMEMWE, NextExtMEM;
  logic [5:0]  NextRegWAddr;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemByteEn;
  logic        DMemReq, DMemWE, DMemAck, StallOut, MisalignFault;
  logic [31:0] MemData, LoadData, ALUOut, FPUOut, PCPlusFour;
  logic [1:0]  DInSrc;
  logic        RegWE;
  logic [5:0]  RegWAddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut), .NextRegB(NextRegB),
    .NextPCPlusFour(NextPCPlusFour), .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
    .NextRegWAddr(NextRegWAddr), .NextMEMSize(NextMEMSize), .NextMEMWE(NextMEMWE),
    .NextExtMEM(NextExtMEM),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemByteEn(DMemByteEn),
    .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemRData(DMemRData), .DMemAck(DMemAck),
    .StallOut(StallOut), .MisalignFault(MisalignFault), .MemData(MemData),
    .LoadData(LoadData), .ALUOut(ALUOut), .FPUOut(FPUOut), .PCPlusFour(PCPlusFour),
    .DInSrc(DInSrc), .RegWE(RegWE), .RegWAddr(RegWAddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [31:0] alu, input logic [31:0] fpu, input logic [31:0] regb,
                        input logic [31:0] pc4, input logic [1:0] src, input logic we,
                        input logic [5:0] waddr, input logic [1:0] size, input logic mwe,
                        input logic ext);
    NextALUOut = alu; NextFPUOut = fpu; NextRegB = regb; NextPCPlusFour = pc4;
    NextDInSrc = src; NextRegWE = we; NextRegWAddr = waddr; NextMEMSize = size;
    NextMEMWE = mwe; NextExtMEM = ext;
  endtask

  task automatic nop();
    bundle(0, 0, 0, 0, 2'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; DMemAck = 1'b0; DMemRData = 32'h0;
    nop();
    cyc(); #1;
    chk("rst_req", {31'b0, DMemReq}, 0);
    chk("rst_be", {28'b0, DMemByteEn}, 0);
    chk("rst_stall", {31'b0, StallOut}, 0);
    chk("rst_memdata", MemData, 0);
    chk("rst_regwe", {31'b0, RegWE}, 0);
    reset = 1'b0;

    // Word load at 0x100, ack after three waiting cycles
    cyc(); bundle(32'h100, 0, 0, 0, 2'd2, 1'b1, 6'd5, 2'd2, 1'b0, 1'b0); #1;
    chk("wl_idle_req", {31'b0, DMemReq}, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); nop(); #1;
      chk($sformatf("wl_stall_%0d", i), {31'b0, StallOut}, 1);
      chk($sformatf("wl_req_%0d", i), {31'b0, DMemReq}, 1);
      chk($sformatf("wl_addr_%0d", i), DMemAddr, 32'h100);
      chk($sformatf("wl_regwe_%0d", i), {31'b0, RegWE}, 0);
    end
    chk("wl_be", {28'b0, DMemByteEn}, 32'hF);
    chk("wl_we", {31'b0, DMemWE}, 0);
    cyc(); DMemAck = 1'b1; DMemRData = 32'hDEADBEEF; #1;
    chk("wl_ack_stall", {31'b0, StallOut}, 0);
    chk("wl_load", LoadData, 32'hDEADBEEF);
    chk("wl_ack_regwe", {31'b0, RegWE}, 1);
    chk("wl_waddr", {26'b0, RegWAddr}, 5);
    chk("wl_memdata", MemData, 32'h100);
    cyc(); DMemAck = 1'b0; #1;
    chk("wl_after_req", {31'b0, DMemReq}, 0);
    chk("wl_after_regwe", {31'b0, RegWE}, 0);

    // Signed then unsigned byte load at 0x103, back to back, zero-wait acks
    bundle(32'h103, 0, 0, 0, 2'd2, 1'b1, 6'd6, 2'd0, 1'b0, 1'b1);
    cyc(); bundle(32'h103, 0, 0, 0, 2'd2, 1'b1, 6'd6, 2'd0, 1'b0, 1'b0);
    DMemAck = 1'b1; DMemRData = 32'h000000F0; #1;
    chk("sb_be", {28'b0, DMemByteEn}, 32'h1);
    chk("sb_addr", DMemAddr, 32'h100);
    chk("sb_load", LoadData, 32'hFFFFFFF0);
    chk("sb_stall", {31'b0, StallOut}, 0);
    cyc(); nop(); #1;
    chk("ub_req", {31'b0, DMemReq}, 1);
    chk("ub_load", LoadData, 32'h000000F0);
    chk("ub_be", {28'b0, DMemByteEn}, 32'h1);

    // Half store at 0x202, zero-wait ack
    cyc(); DMemAck = 1'b0;
    bundle(32'h202, 0, 32'h1234ABCD, 0, 2'd0, 1'b0, 6'd0, 2'd1, 1'b1, 1'b0); #1;
    chk("hs_idle_stall", {31'b0, StallOut}, 0);
    cyc(); nop(); DMemAck = 1'b1; #1;
    chk("hs_be", {28'b0, DMemByteEn}, 32'h3);
    chk("hs_wdata", DMemWData, 32'hABCDABCD);
    chk("hs_we", {31'b0, DMemWE}, 1);
    chk("hs_req", {31'b0, DMemReq}, 1);
    chk("hs_stall", {31'b0, StallOut}, 0);
    chk("hs_addr", DMemAddr, 32'h200);

    // Misaligned word load at 0x101
    cyc(); DMemAck = 1'b0;
    bundle(32'h101, 0, 0, 0, 2'd2, 1'b1, 6'd4, 2'd2, 1'b0, 1'b0); #1;
    chk("ma_pre_req", {31'b0, DMemReq}, 0);
    cyc(); bundle(32'h77, 0, 0, 0, 2'd0, 1'b1, 6'd9, 2'd0, 1'b0, 1'b0); #1;
    chk("ma_fault", {31'b0, MisalignFault}, 1);
    chk("ma_req", {31'b0, DMemReq}, 0);
    chk("ma_regwe", {31'b0, RegWE}, 0);
    chk("ma_stall", {31'b0, StallOut}, 0);
    chk("ma_be", {28'b0, DMemByteEn}, 0);
    cyc(); nop(); #1;
    chk("ma_next_fault", {31'b0, MisalignFault}, 0);
    chk("ma_next_alu", ALUOut, 32'h77);
    chk("ma_next_regwe", {31'b0, RegWE}, 1);
    chk("ma_next_waddr", {26'b0, RegWAddr}, 9);
    chk("ma_next_memdata", MemData, 32'h77);

    // Ack while frozen: result parks in HOLD
    cyc(); bundle(32'h300, 0, 0, 0, 2'd2, 1'b1, 6'd3, 2'd2, 1'b0, 1'b0); #1;
    chk("hd_pre_req", {31'b0, DMemReq}, 0);
    cyc(); nop(); stall = 1'b1; DMemAck = 1'b1; DMemRData = 32'h55AA55AA; #1;
    chk("hd_ack_stall", {31'b0, StallOut}, 0);
    chk("hd_ack_load", LoadData, 32'h55AA55AA);
    for (int i = 1; i <= 2; i++) begin
      cyc(); DMemAck = 1'b0; DMemRData = 32'h0; #1;
      chk($sformatf("hd_req_%0d", i), {31'b0, DMemReq}, 0);
      chk($sformatf("hd_load_%0d", i), LoadData, 32'h55AA55AA);
      chk($sformatf("hd_alu_%0d", i), ALUOut, 32'h300);
    end
    cyc(); stall = 1'b0; #1;
    chk("hd_release_load", LoadData, 32'h55AA55AA);
    chk("hd_release_req", {31'b0, DMemReq}, 0);
    chk("hd_release_regwe", {31'b0, RegWE}, 1);
    cyc(); bundle(32'h400, 0, 0, 0, 2'd2, 1'b1, 6'd2, 2'd2, 1'b0, 1'b0); #1;
    chk("hd_done_load", LoadData, 0);
    chk("hd_done_alu", ALUOut, 0);

    // Reset during ACCESS, late ack ignored, then an ALU op passes through
    cyc(); nop(); #1;
    chk("ra_req", {31'b0, DMemReq}, 1);
    #2 reset = 1'b1; #1;
    chk("ra_req_drop", {31'b0, DMemReq}, 0);
    chk("ra_be", {28'b0, DMemByteEn}, 0);
    chk("ra_addr", DMemAddr, 0);
    chk("ra_alu", ALUOut, 0);
    chk("ra_stall", {31'b0, StallOut}, 0);
    cyc(); DMemAck = 1'b1; DMemRData = 32'h12345678; #1;
    chk("ra_late_req", {31'b0, DMemReq}, 0);
    cyc(); reset = 1'b0;
    bundle(32'hCAFE, 32'h11, 0, 0, 2'd0, 1'b1, 6'd7, 2'd0, 1'b0, 1'b0); #1;
    chk("ra_post_req", {31'b0, DMemReq}, 0);
    chk("ra_post_load", LoadData, 0);
    cyc(); nop(); DMemAck = 1'b0; #1;
    chk("alu_memdata", MemData, 32'hCAFE);
    chk("alu_regwe", {31'b0, RegWE}, 1);
    chk("alu_req", {31'b0, DMemReq}, 0);

    // FPU and PC+4 forwarding selections
    bundle(32'h9, 32'h1234, 0, 32'h44, 2'd1, 1'b1, 6'd1, 2'd0, 1'b0, 1'b0);
    cyc(); bundle(32'h9, 32'h1234, 0, 32'h44, 2'd3, 1'b1, 6'd1, 2'd0, 1'b0, 1'b0); #1;
    chk("fpu_memdata", MemData, 32'h1234);
    cyc(); nop(); #1;
    chk("pc_memdata", MemData, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage that receives the execute stage's result bundle and issues loads and stores to a variable-latency data-memory port using a req/ack handshake.
- Aligns store data and byte enables to big-endian lanes, and extracts and extends load data.
- Drives the forwarding value back to execute and the writeback bundle forward.
- Requests a pipeline freeze while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global freeze from hazard control
- NextALUOut  in  32  ALU result; the effective address for memory ops
- NextFPUOut  in  32  FPU result
- NextRegB  in  32  store data
- NextPCPlusFour  in  32  link value
- NextDInSrc  in  2  writeback source: 0 ALU, 1 FPU, 2 MEM, 3 PC+4
- NextRegWE  in  1  register write enable
- NextRegWAddr  in  6  destination register
- NextMEMSize  in  2  0 byte, 1 half, 2 word, 3 reserved
- NextMEMWE  in  1  store
- NextExtMEM  in  1  sign-extend load
- DMemAddr  out  32  word-aligned address (low 2 bits = 0)
- DMemWData  out  32  lane-replicated store data
- DMemByteEn  out  4  lane enables; bit 0 = bits [0:7]
- DMemReq  out  1  access request
- DMemWE  out  1  write qualifier
- DMemRData  in  32  read data, valid with DMemAck
- DMemAck  in  1  access complete
- StallOut  out  1  stage busy; upstream must hold
- MisalignFault  out  1  latched op misaligned or reserved size
- MemData  out  32  forwarding value for execute
- LoadData  out  32  aligned and extended load result
- ALUOut, FPUOut, PCPlusFour  out  32 each  forwarded values
- DInSrc  out  2  forwarded writeback source
- RegWE  out  1  forwarded write enable, qualified
- RegWAddr  out  6  forwarded destination register

Behaviour:
- Pipeline register:
  - Captures all Next* inputs at posedge clk when cap_en = ~stall & ~StallOut; otherwise holds.
  - Async reset clears every field to 0.
- mem_op = (DInSrc==2) | MEMWE.
- Fault condition, combinational on latched fields: MEMSize==3, or half with addr[31]==1, or word with addr[30:31]!=0.
  - MisalignFault = mem_op & fault.
  - A faulting op never requests memory.
- FSM states: IDLE, ACCESS, HOLD. Reset -> IDLE.
- On every capture, next state is ACCESS if the captured op is a memory op and not faulting; otherwise IDLE.
- IDLE:
  - DMemReq=0, StallOut=0.
- ACCESS:
  - DMemReq=1; address, data, enables and WE held stable.
  - StallOut = ~DMemAck.
  - DMemAck & stall -> latch extracted load into hold_buf; go to HOLD; no reissue.
  - DMemAck & ~stall -> capture the next bundle (zero-wait ack gives no stall cycle).
- HOLD:
  - DMemReq=0, StallOut=0; LoadData sourced from hold_buf.
  - ~stall -> capture the next bundle.
- Store alignment:
  - byte: WData = 4 copies of RegB[24:31]; ByteEn one-hot at lane addr[30:31] (lane 0 = 1000).
  - half: WData = 2 copies of RegB[16:31]; ByteEn 1100 if addr[30]==0, else 0011.
  - word: WData = RegB; ByteEn 1111.
- Loads:
  - DMemWE=0; ByteEn as above.
  - Selected lane(s) right-justified into LoadData.
  - Upper bits = sign bit if ExtMEM, else 0.
- LoadData is combinational from DMemRData while in ACCESS, and from hold_buf in HOLD.
- MemData = ALUOut, FPUOut or PCPlusFour according to DInSrc (0, 1, 3); for DInSrc==2 it is ALUOut.
- RegWE output = reg_we & ~StallOut & ~MisalignFault.
- Reset asserted mid-ACCESS: DMemReq drops immediately (async); any late ack is ignored.
- Reset values: all outputs 0, except DMemByteEn = 0000.

Decomposition:
- Package mem_stage_pkg holds:
  - DInSrc codes DIN_ALU/FPU/MEM/PC.
  - MEMSize codes SZ_BYTE/HALF/WORD/RSVD.
  - FSM state encoding.
- One combinational sub-module, mem_lane_align:
  - store path: size, addr[30:31], RegB -> WData, ByteEn.
  - load path: size, addr[30:31], ext, RData -> LoadData.

Test Plan:
- Word load, addr 0x100, ack after 3 cycles, RData 0xDEADBEEF -> StallOut high 3 cycles; Req stable; LoadData 0xDEADBEEF; RegWE high only in the ack cycle.
- Signed byte load, addr 0x103, RData 0x000000F0, ExtMEM=1 -> ByteEn 0001; LoadData 0xFFFFFFF0. Same with ExtMEM=0 -> 0x000000F0.
- Half store, addr 0x202, RegB 0x1234ABCD, zero-wait ack -> ByteEn 0011, WData 0xABCDABCD, DMemWE=1, StallOut never high.
- Word load at addr 0x101 -> MisalignFault=1, DMemReq never asserted, RegWE=0, next bundle captured the following cycle.
- Ack arrives while stall=1, RData 0x55AA55AA -> state HOLD, Req low, LoadData 0x55AA55AA held until stall drops, no second request.
- Reset asserted during ACCESS -> DMemReq low immediately; all outputs 0; a subsequent ALU op (DInSrc 0) passes through with MemData = ALUOut.
